// File: rtl/wb_sdspi_byte_server.sv
// Wishbone byte server for raw SD boot: fetches 512-byte blocks from an SD read
// core into a small FIFO and hands out one byte per RQ_DATA bus transaction.
module wb_sdspi_byte_server #(
    parameter int          WB_DATA     = 32,
    parameter logic [31:0] BASE_ADDR   = 32'h9200_0000,
    parameter int          FIFO_DEPTH  = 16,
    parameter int          BLOCK_BYTES = 512
) (
    input  logic                 wb_clk,
    input  logic                 wb_rst_n,
    input  logic [WB_DATA-1:0]   wb_adr_i,
    input  logic [WB_DATA-1:0]   wb_dat_i,
    input  logic                 wb_we_i,
    input  logic [WB_DATA/8-1:0] wb_sel_i,
    input  logic                 wb_cyc_i,
    input  logic                 wb_stb_i,
    output logic [WB_DATA-1:0]   wb_dat_o,
    output logic                 wb_ack_o,
    output logic                 sd_rd_req,
    input  logic                 sd_rd_ack,
    output logic [31:0]          sd_blk_addr,
    input  logic [7:0]           sd_byte,
    input  logic                 sd_byte_valid,
    output logic                 sd_byte_ready,
    input  logic                 sd_rd_err,
    output logic [4:0]           sclk_div,
    output logic [1:0]           bus_state_o,
    output logic [1:0]           eng_state_o
);

    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = PW + 1;
    localparam int BW = $clog2(BLOCK_BYTES);

    localparam logic [WB_DATA-1:0] A_BLK  = WB_DATA'(BASE_ADDR);
    localparam logic [WB_DATA-1:0] A_RQ   = A_BLK + WB_DATA'(1);
    localparam logic [WB_DATA-1:0] A_SCLK = A_BLK + WB_DATA'(2);
    localparam logic [WB_DATA-1:0] A_STAT = A_BLK + WB_DATA'(3);

    typedef enum logic [1:0] {B_IDLE, B_RQ, B_ACK, B_REL} bus_state_t;
    typedef enum logic [1:0] {E_IDLE, E_REQ, E_STREAM} eng_state_t;

    bus_state_t         bus_q;
    eng_state_t         eng_q;
    logic               ack_q;
    logic [WB_DATA-1:0] dat_q;
    logic [4:0]         sclk_q;
    logic               req_q;
    logic [31:0]        blk_addr_q;
    logic               armed_q;
    logic               err_q;
    logic               flush_q;
    logic               discard_q;
    logic [BW-1:0]      byte_cnt_q;

    logic [7:0]         mem [FIFO_DEPTH];
    logic [PW-1:0]      wr_ptr_q;
    logic [PW-1:0]      rd_ptr_q;
    logic [CW-1:0]      count_q;
    logic [CW-1:0]      count_d;

    logic        bus_start;
    logic        hit_blk;
    logic        hit_rq;
    logic        hit_sclk;
    logic        hit_stat;
    logic        wr_blk;
    logic        fifo_empty;
    logic        fifo_full;
    logic        pop;
    logic        push;
    logic        byte_hs;
    logic        last_byte;
    logic [31:0] status;
    logic        unused_sel;

    assign unused_sel = ^wb_sel_i;

    assign bus_start  = (bus_q == B_IDLE) && wb_cyc_i && wb_stb_i;
    assign hit_blk    = (wb_adr_i == A_BLK);
    assign hit_rq     = (wb_adr_i == A_RQ);
    assign hit_sclk   = (wb_adr_i == A_SCLK);
    assign hit_stat   = (wb_adr_i == A_STAT);
    assign wr_blk     = bus_start && wb_we_i && hit_blk;

    assign fifo_empty = (count_q == '0);
    assign fifo_full  = (count_q == CW'(FIFO_DEPTH));
    assign pop        = (bus_q == B_RQ) && !err_q && !flush_q && !fifo_empty;

    // While discarding a flushed block the core is drained at full rate.
    assign sd_byte_ready = (eng_q == E_STREAM) && (discard_q || flush_q || !fifo_full);
    assign byte_hs       = sd_byte_valid && sd_byte_ready;
    assign push          = byte_hs && !discard_q && !flush_q;
    assign last_byte     = (byte_cnt_q == BW'(BLOCK_BYTES - 1));

    assign status = {armed_q, err_q, 22'b0, 8'(count_q)};

    assign wb_ack_o    = ack_q;
    assign wb_dat_o    = dat_q;
    assign sclk_div    = sclk_q;
    assign sd_rd_req   = req_q;
    assign sd_blk_addr = blk_addr_q;
    assign bus_state_o = bus_q;
    assign eng_state_o = eng_q;

    // Wishbone side: ack is asserted exactly in B_ACK, then waits for strobe release.
    always_ff @(posedge wb_clk or negedge wb_rst_n) begin
        if (!wb_rst_n) begin
            bus_q  <= B_IDLE;
            ack_q  <= 1'b0;
            dat_q  <= '0;
            sclk_q <= '0;
        end else begin
            case (bus_q)
                B_IDLE: begin
                    if (bus_start) begin
                        dat_q <= '0;
                        if (wb_we_i) begin
                            if (hit_sclk) sclk_q <= wb_dat_i[4:0];
                            if (hit_rq) begin
                                bus_q <= B_RQ;
                            end else begin
                                bus_q <= B_ACK;
                                ack_q <= 1'b1;
                            end
                        end else begin
                            bus_q <= B_ACK;
                            ack_q <= 1'b1;
                            if (hit_blk)       dat_q <= WB_DATA'(blk_addr_q);
                            else if (hit_sclk) dat_q <= WB_DATA'(sclk_q);
                            else if (hit_stat) dat_q <= WB_DATA'(status);
                        end
                    end
                end
                B_RQ: begin
                    if (err_q) begin
                        dat_q <= WB_DATA'(32'h8000_0000);
                        ack_q <= 1'b1;
                        bus_q <= B_ACK;
                    end else if (pop) begin
                        dat_q <= WB_DATA'(mem[rd_ptr_q]);
                        ack_q <= 1'b1;
                        bus_q <= B_ACK;
                    end
                end
                B_ACK: begin
                    ack_q <= 1'b0;
                    bus_q <= B_REL;
                end
                default: begin
                    if (!(wb_cyc_i && wb_stb_i)) bus_q <= B_IDLE;
                end
            endcase
        end
    end

    // Read engine plus the shared block address / arm / error state.
    always_ff @(posedge wb_clk or negedge wb_rst_n) begin
        if (!wb_rst_n) begin
            eng_q      <= E_IDLE;
            req_q      <= 1'b0;
            blk_addr_q <= '0;
            armed_q    <= 1'b0;
            err_q      <= 1'b0;
            flush_q    <= 1'b0;
            discard_q  <= 1'b0;
            byte_cnt_q <= '0;
        end else begin
            flush_q <= wr_blk;
            if (wr_blk) begin
                blk_addr_q <= wb_dat_i[31:0];
                armed_q    <= 1'b1;
                err_q      <= 1'b0;
            end
            case (eng_q)
                E_IDLE: begin
                    if (armed_q && !err_q && !flush_q) begin
                        eng_q <= E_REQ;
                        req_q <= 1'b1;
                    end
                end
                E_REQ: begin
                    if (sd_rd_ack) begin
                        req_q      <= 1'b0;
                        byte_cnt_q <= '0;
                        discard_q  <= flush_q;
                        eng_q      <= E_STREAM;
                    end
                end
                E_STREAM: begin
                    if (flush_q) discard_q <= 1'b1;
                    if (byte_hs) begin
                        byte_cnt_q <= byte_cnt_q + BW'(1);
                        if (last_byte) begin
                            eng_q     <= E_IDLE;
                            discard_q <= 1'b0;
                            if (!discard_q && !flush_q && !wr_blk)
                                blk_addr_q <= blk_addr_q + 32'd1;
                        end
                    end
                end
                default: eng_q <= E_IDLE;
            endcase
            // A read error aborts the engine and wins over a same-cycle rearm.
            if (sd_rd_err && (eng_q == E_REQ || eng_q == E_STREAM)) begin
                err_q     <= 1'b1;
                armed_q   <= 1'b0;
                eng_q     <= E_IDLE;
                req_q     <= 1'b0;
                discard_q <= 1'b0;
            end
        end
    end

    always_comb begin
        count_d = count_q;
        if (flush_q)           count_d = '0;
        else if (push && !pop) count_d = count_q + CW'(1);
        else if (pop && !push) count_d = count_q - CW'(1);
    end

    always_ff @(posedge wb_clk or negedge wb_rst_n) begin
        if (!wb_rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            count_q <= count_d;
            if (flush_q) begin
                wr_ptr_q <= '0;
                rd_ptr_q <= '0;
            end else begin
                if (push) wr_ptr_q <= wr_ptr_q + PW'(1);
                if (pop)  rd_ptr_q <= rd_ptr_q + PW'(1);
            end
        end
    end

    always_ff @(posedge wb_clk) begin
        if (push) mem[wr_ptr_q] <= sd_byte;
    end

endmodule

// File: tb/tb_wb_sdspi_byte_server.sv
// Directed bench for wb_sdspi_byte_server with a behavioural SD read core
// that records requested block addresses and queues the bytes it delivers.
module tb_wb_sdspi_byte_server;

    localparam logic [31:0] A_BLK  = 32'h9200_0000;
    localparam logic [31:0] A_RQ   = 32'h9200_0001;
    localparam logic [31:0] A_SCLK = 32'h9200_0002;
    localparam logic [31:0] A_STAT = 32'h9200_0003;

    logic        wb_clk;
    logic        wb_rst_n;
    logic [31:0] wb_adr_i;
    logic [31:0] wb_dat_i;
    logic        wb_we_i;
    logic [3:0]  wb_sel_i;
    logic        wb_cyc_i;
    logic        wb_stb_i;
    logic [31:0] wb_dat_o;
    logic        wb_ack_o;
    logic        sd_rd_req;
    logic        sd_rd_ack;
    logic [31:0] sd_blk_addr;
    logic [7:0]  sd_byte;
    logic        sd_byte_valid;
    logic        sd_byte_ready;
    logic        sd_rd_err;
    logic [4:0]  sclk_div;
    logic [1:0]  bus_state_o;
    logic [1:0]  eng_state_o;

    int total = 0;
    int bad   = 0;
    int cyc_cnt = 0;
    int last_ack_cyc = 0;
    int first_valid_cyc = 0;

    int cfg_ack_delay   = 2;
    int cfg_first_delay = 0;
    int cfg_err_at      = -1;

    logic [7:0]  exp_q[$];
    logic [31:0] req_log[$];

    wb_sdspi_byte_server dut (
        .wb_clk        (wb_clk),
        .wb_rst_n      (wb_rst_n),
        .wb_adr_i      (wb_adr_i),
        .wb_dat_i      (wb_dat_i),
        .wb_we_i       (wb_we_i),
        .wb_sel_i      (wb_sel_i),
        .wb_cyc_i      (wb_cyc_i),
        .wb_stb_i      (wb_stb_i),
        .wb_dat_o      (wb_dat_o),
        .wb_ack_o      (wb_ack_o),
        .sd_rd_req     (sd_rd_req),
        .sd_rd_ack     (sd_rd_ack),
        .sd_blk_addr   (sd_blk_addr),
        .sd_byte       (sd_byte),
        .sd_byte_valid (sd_byte_valid),
        .sd_byte_ready (sd_byte_ready),
        .sd_rd_err     (sd_rd_err),
        .sclk_div      (sclk_div),
        .bus_state_o   (bus_state_o),
        .eng_state_o   (eng_state_o)
    );

    // clock / reset
    initial wb_clk = 1'b0;
    always #5 wb_clk = ~wb_clk;
    always @(posedge wb_clk) cyc_cnt <= cyc_cnt + 1;

    initial begin
        #900000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    function automatic logic [7:0] sd_data(input logic [31:0] blk, input int i);
        logic [7:0] iv;
        iv = 8'(i);
        return iv ^ blk[7:0] ^ 8'h20;
    endfunction

    // SD read core model: ack after a delay, then stream one block
    initial begin
        logic [31:0] blk;
        int ad, fd, ea, n, i;
        logic took;
        sd_rd_ack = 1'b0; sd_byte = 8'h00; sd_byte_valid = 1'b0; sd_rd_err = 1'b0;
        forever begin
            @(negedge wb_clk);
            if (sd_rd_req === 1'b1) begin
                ad = cfg_ack_delay; fd = cfg_first_delay; ea = cfg_err_at;
                repeat (ad) @(negedge wb_clk);
                blk = sd_blk_addr;
                sd_rd_ack = 1'b1;
                req_log.push_back(blk);
                n = (ea >= 0 && ea < 512) ? ea : 512;
                for (int k = 0; k < n; k++) exp_q.push_back(sd_data(blk, k));
                @(negedge wb_clk);
                sd_rd_ack = 1'b0;
                repeat (fd) @(negedge wb_clk);
                i = 0;
                while (i < 512) begin
                    if (i == ea) begin
                        sd_byte_valid = 1'b0;
                        sd_rd_err = 1'b1;
                        @(negedge wb_clk);
                        sd_rd_err = 1'b0;
                        break;
                    end
                    sd_byte = sd_data(blk, i);
                    sd_byte_valid = 1'b1;
                    if (i == 0) first_valid_cyc = cyc_cnt;
                    took = sd_byte_ready;
                    @(negedge wb_clk);
                    if (took) i++;
                end
                sd_byte_valid = 1'b0;
            end
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // driver: one transaction, we/dat only valid on the first cycle
    task automatic bus_xfer(input logic [31:0] adr, input logic we, input logic [31:0] dat,
                            output logic [31:0] rdata, output int lat);
        wb_adr_i = adr; wb_we_i = we; wb_dat_i = dat;
        wb_cyc_i = 1'b1; wb_stb_i = 1'b1;
        lat = 0; rdata = '0;
        forever begin
            @(negedge wb_clk);
            lat++;
            if (lat == 1) begin
                wb_we_i  = 1'b0;
                wb_dat_i = 32'hDEAD_BEEF;
            end
            if (wb_ack_o === 1'b1) begin
                rdata = wb_dat_o;
                last_ack_cyc = cyc_cnt;
                break;
            end
            if (lat > 4000) begin
                total++; bad++;
                $error("FAIL bus_timeout adr=%h observed=no_ack expected=ack", adr);
                break;
            end
        end
        wb_cyc_i = 1'b0; wb_stb_i = 1'b0;
        @(negedge wb_clk);
        check("ack_single", {31'b0, wb_ack_o}, 32'd0);
        @(negedge wb_clk);
    endtask

    task automatic rq_byte(input string tag, output int lat);
        logic [31:0] r;
        logic [7:0]  e;
        bus_xfer(A_RQ, 1'b1, 32'h0, r, lat);
        if (exp_q.size() == 0) begin
            total++; bad++;
            $error("FAIL %s observed=%h expected=none_queued", tag, r);
        end else begin
            e = exp_q.pop_front();
            check(tag, r, {24'h0, e});
        end
    endtask

    task automatic wait_log(input int n);
        int t;
        t = 0;
        while (req_log.size() < n && t < 3000) begin
            @(negedge wb_clk);
            t++;
        end
        check("req_seen", 32'(req_log.size() >= n), 32'd1);
    endtask

    initial begin
        logic [31:0] rd;
        int lat, base, acks, t;
        wb_rst_n = 1'b0; wb_adr_i = '0; wb_dat_i = '0; wb_we_i = 1'b0;
        wb_sel_i = 4'hF; wb_cyc_i = 1'b0; wb_stb_i = 1'b0;
        repeat (3) @(negedge wb_clk);
        check("rst_ack", {31'b0, wb_ack_o}, 32'd0);
        check("rst_dat", wb_dat_o, 32'd0);
        check("rst_req", {31'b0, sd_rd_req}, 32'd0);
        check("rst_ready", {31'b0, sd_byte_ready}, 32'd0);
        check("rst_sclk", {27'b0, sclk_div}, 32'd0);
        check("rst_addr", sd_blk_addr, 32'd0);
        check("rst_states", {28'b0, bus_state_o, eng_state_o}, 32'd0);
        wb_rst_n = 1'b1;
        @(negedge wb_clk);

        bus_xfer(A_STAT, 1'b0, 32'h0, rd, lat);
        check("status_reset", rd, 32'h0);
        bus_xfer(A_BLK + 32'd8, 1'b0, 32'h0, rd, lat);
        check("unmapped_read", rd, 32'h0);

        // sclk write, then a held-strobe readback must ack only once
        bus_xfer(A_SCLK, 1'b1, 32'h0000_00EA, rd, lat);
        check("sclk_div", {27'b0, sclk_div}, 32'h0A);
        wb_adr_i = A_SCLK; wb_we_i = 1'b0; wb_cyc_i = 1'b1; wb_stb_i = 1'b1;
        acks = 0;
        for (int k = 0; k < 8; k++) begin
            @(negedge wb_clk);
            if (wb_ack_o === 1'b1) begin
                acks++;
                rd = wb_dat_o;
            end
        end
        wb_cyc_i = 1'b0; wb_stb_i = 1'b0;
        repeat (2) @(negedge wb_clk);
        check("sclk_ack_count", 32'(acks), 32'd1);
        check("sclk_read", rd, 32'h0000_000A);

        // block 0x20 and auto-increment to 0x21
        exp_q.delete();
        bus_xfer(A_BLK, 1'b1, 32'h20, rd, lat);
        repeat (60) @(negedge wb_clk);
        bus_xfer(A_STAT, 1'b0, 32'h0, rd, lat);
        check("status_full", rd, 32'h8000_0010);
        rq_byte("rq_first", lat);
        check("rq_latency", 32'(lat), 32'd2);
        for (int k = 1; k < 1024; k++) rq_byte("rq_stream", lat);
        check("req0_addr", (req_log.size() > 0) ? req_log[0] : 32'hFFFF_FFFF, 32'h20);
        check("req1_addr", (req_log.size() > 1) ? req_log[1] : 32'hFFFF_FFFF, 32'h21);
        bus_xfer(A_BLK, 1'b0, 32'h0, rd, lat);
        check("blk_after_two", rd, 32'h22);

        // restart at 0x20, then flush to 0x100 after 100 bytes
        exp_q.delete();
        base = req_log.size();
        bus_xfer(A_BLK, 1'b1, 32'h20, rd, lat);
        for (int k = 0; k < 100; k++) rq_byte("rq_pre_flush", lat);
        check("req_restart", (req_log.size() > base) ? req_log[base] : 32'hFFFF_FFFF, 32'h20);
        exp_q.delete();
        base = req_log.size();
        bus_xfer(A_BLK, 1'b1, 32'h100, rd, lat);
        rq_byte("rq_flush_first", lat);
        check("rq_flush_first_val", rd, rd);
        for (int k = 1; k < 20; k++) rq_byte("rq_post_flush", lat);
        check("req_flush_count", 32'(req_log.size() - base), 32'd1);
        check("req_flush_addr", (req_log.size() > base) ? req_log[base] : 32'hFFFF_FFFF, 32'h100);

        // slow first byte: ack held off until the byte arrives
        cfg_first_delay = 40;
        exp_q.delete();
        base = req_log.size();
        bus_xfer(A_BLK, 1'b1, 32'h200, rd, lat);
        wait_log(base + 1);
        cfg_first_delay = 0;
        rq_byte("rq_delayed", lat);
        check("ack_after_byte", 32'(last_ack_cyc > first_valid_cyc), 32'd1);

        // read error while a request is pending
        cfg_first_delay = 40;
        cfg_err_at = 0;
        exp_q.delete();
        base = req_log.size();
        bus_xfer(A_BLK, 1'b1, 32'h300, rd, lat);
        wait_log(base + 1);
        cfg_first_delay = 0;
        cfg_err_at = -1;
        bus_xfer(A_RQ, 1'b1, 32'h0, rd, lat);
        check("rq_err_data", rd, 32'h8000_0000);
        bus_xfer(A_STAT, 1'b0, 32'h0, rd, lat);
        check("status_err", rd, 32'h4000_0000);
        repeat (60) @(negedge wb_clk);
        check("no_req_after_err", 32'(req_log.size() - base), 32'd1);
        check("req_low_after_err", {31'b0, sd_rd_req}, 32'd0);
        exp_q.delete();
        bus_xfer(A_BLK, 1'b1, 32'h40, rd, lat);
        rq_byte("rq_rearm", lat);
        bus_xfer(A_STAT, 1'b0, 32'h0, rd, lat);
        check("status_rearm", rd & 32'hC000_0000, 32'h8000_0000);

        // asynchronous reset while a request is outstanding
        cfg_ack_delay = 30;
        exp_q.delete();
        bus_xfer(A_BLK, 1'b1, 32'h50, rd, lat);
        t = 0;
        while (sd_rd_req !== 1'b1 && t < 3000) begin
            @(negedge wb_clk);
            t++;
        end
        check("req_before_reset", {31'b0, sd_rd_req}, 32'd1);
        check("addr_before_reset", sd_blk_addr, 32'h50);
        #2 wb_rst_n = 1'b0;
        #1;
        check("async_req_drop", {31'b0, sd_rd_req}, 32'd0);
        check("async_sclk", {27'b0, sclk_div}, 32'd0);
        check("async_addr", sd_blk_addr, 32'd0);
        @(negedge wb_clk);
        wb_rst_n = 1'b1;
        @(negedge wb_clk);
        bus_xfer(A_STAT, 1'b0, 32'h0, rd, lat);
        check("status_after_reset", rd, 32'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/wb_sdspi_byte_server.md
Name: wb_sdspi_byte_server

Overview:
- Wishbone slave at SDSPI_WB_ADDR that the raw-boot master talks to.
- Takes block-address, byte-request and SCLK-speed commands from the bus.
- Drives a block-level SD read core: one 512-byte block per request, bytes streamed with valid/ready.
- Bytes pass through an internal FIFO and are served one per byte-request transaction. The block address auto-increments every 512 bytes, so a loader can read consecutive blocks after a single address write.

Parameters:
WB_DATA, 32, Wishbone data/address width
BASE_ADDR, 32'h92000000, register base; offsets +0 BLOCK_DIR, +1 RQ_DATA, +2 SCLK_SPEED, +3 STATUS (byte offsets, exact match)
FIFO_DEPTH, 16, byte FIFO entries (power of two, >=2)
BLOCK_BYTES, 512, bytes per SD block

Ports:
wb_clk  in  1  clock
wb_rst_n  in  1  asynchronous active-low reset
wb_adr_i  in  WB_DATA  address
wb_dat_i  in  WB_DATA  write data
wb_we_i  in  1  write enable
wb_sel_i  in  WB_DATA/8  byte select (ignored, full-word access)
wb_cyc_i  in  1  cycle
wb_stb_i  in  1  strobe
wb_dat_o  out  WB_DATA  read data
wb_ack_o  out  1  acknowledge
sd_rd_req  out  1  block read request, level
sd_rd_ack  in  1  SD core accepted request, 1-cycle pulse
sd_blk_addr  out  32  block address for the request
sd_byte  in  8  streamed byte
sd_byte_valid  in  1  byte valid
sd_byte_ready  out  1  byte accepted
sd_rd_err  in  1  read error, 1-cycle pulse
sclk_div  out  5  SPI clock divider to SD core

Behaviour:
- Reset values: all outputs 0. blk_addr=0, sclk_div=0, FIFO empty, armed=0, err=0, both FSMs idle.
- Bus transaction start:
  - A transaction starts on the first cycle with cyc&stb while the bus FSM is in B_IDLE.
  - adr, we and dat are captured on that cycle only; later changes of we/dat within the same cyc&stb are ignored (the master drops we after one cycle).
- Bus FSM:
  - B_IDLE -> B_ACK for a write to BLOCK_DIR or SCLK_SPEED, any read, or any unmapped access. Unmapped accesses are acked with data 0.
  - B_IDLE -> B_RQ for a write to RQ_DATA.
  - B_RQ waits for FIFO non-empty, then pops one byte into dat_o[7:0] (upper bits 0) -> B_ACK.
  - If err is set while in B_RQ (or on entry), go -> B_ACK with dat_o=32'h8000_0000.
  - B_ACK: wb_ack_o=1 for exactly one cycle -> B_REL.
  - B_REL: waits until cyc&stb are low -> B_IDLE. There is no second ack for a held strobe.
- Register effects, applied in the B_IDLE capture cycle:
  - BLOCK_DIR write: blk_addr<=dat, armed<=1, err<=0, flush requested.
  - SCLK_SPEED write: sclk_div<=dat[4:0].
  - Reads return: BLOCK_DIR -> blk_addr; SCLK_SPEED -> sclk_div; STATUS -> {armed, err, 22'b0, fifo_count[7:0]}.
- Read engine FSM:
  - E_IDLE -> E_REQ when armed && !err && !flush.
  - E_REQ: sd_rd_req=1, sd_blk_addr=blk_addr, both held until sd_rd_ack -> E_STREAM with byte_cnt=0.
  - E_STREAM: sd_byte_ready = !fifo_full. A byte is pushed on valid&ready and byte_cnt increments.
  - On the BLOCK_BYTES-th byte: blk_addr<=blk_addr+1 (32-bit wrap) -> E_IDLE.
- Flush (BLOCK_DIR write):
  - In E_IDLE or E_REQ before ack: FIFO cleared next cycle, request restarts at the new address. sd_rd_req may stay high; sd_blk_addr updates.
  - In E_STREAM: FIFO cleared. Remaining bytes of the current block are accepted with ready=1 and discarded; the post-block increment is suppressed; then -> E_IDLE and restart at the new address.
- sd_rd_err in E_REQ or E_STREAM: err<=1, armed<=0, engine -> E_IDLE, FIFO kept.
- FIFO:
  - Push and pop in the same cycle keep the count unchanged.
  - No push when full (ready is low); no pop when empty.
  - Flush has priority over push and pop.
- Latency: a byte already in the FIFO is acked 2 cycles after cyc&stb are first sampled high (capture cycle, B_RQ pop, B_ACK).
- Reset mid-operation: everything returns to reset values immediately; sd_rd_req drops asynchronously.

Test Plan:
- Write SCLK_SPEED=5'h0A, read it back -> sclk_div=0x0A, read data 0x0000000A, exactly one ack pulse per transaction.
- Write BLOCK_DIR=0x20, SD model acks and streams bytes i&0xFF -> one sd_rd_req with addr 0x20. 512 RQ_DATA transactions (one write cycle, then stb with we=0) return 0x00..0xFF twice.
- Continue to 1024 RQ transactions -> second request with sd_blk_addr=0x21, data continuous, and no byte lost while the FIFO sits full with valid held high.
- Issue an RQ when the FIFO is empty and the SD model has a 40-cycle delay before the first byte -> ack held off until the first byte, data correct.
- Write BLOCK_DIR=0x100 after 100 bytes of block 0x20 -> rest of block 0x20 discarded, next request addr 0x100, first served byte = byte 0 of block 0x100.
- Pulse sd_rd_err during streaming while an RQ is pending -> ack with 0x80000000, STATUS err=1 armed=0, no new request until BLOCK_DIR is written.
